dcm_lock_seq: RTL and testbench
===============================

# dcm_lock_seq

Reset and lock sequencer for the two DCM_SP clock synthesizers: the CPU DCM producing the 75 MHz clock and the video DCM producing 50 MHz in both phases. It runs on the 50 MHz board clock. It pulses the DCMs' RST, waits for both LOCKED outputs, and enforces a settle interval before releasing system reset to the CPU and video domains. It retries on lock timeout or lock loss, and declares a sticky failure after a bounded number of retries.

## Interface
Parameters:
- RST_PULSE, 4 — cycles DCM_RST is held high per attempt; must be ≥3 (DCM_SP minimum).
- LOCK_TIMEOUT, 50000 — cycles to wait for both locks (1 ms at 50 MHz); range 1..65535.
- SETTLE, 1024 — cycles both locks must stay high before SYS_RST is released; range 1..65535.
- RETRY_MAX, 7 — retries allowed before FAIL; range 0..7.

Ports:
- CLK in 1 — 50 MHz board clock, buffered; the same net that drives the DCMs' CLKIN.
- RST in 1 — asynchronous, active-high reset.
- CPU_LOCKED in 1 — CPU DCM LOCKED; asynchronous to CLK.
- VID_LOCKED in 1 — video DCM LOCKED; asynchronous.
- CPU_FXSTOP in 1 — CPU DCM STATUS[2] (CLKFX stopped); asynchronous.
- VID_FXSTOP in 1 — video DCM STATUS[2]; asynchronous.
- DCM_RST out 1 — drives RST of both DCMs.
- SYS_RST out 1 — active-high reset to the CPU and video domain reset synchronizers.
- READY out 1 — high only in RUN.
- FAIL out 1 — sticky failure flag.
- RETRY_CNT out 3 — retries consumed in the current bring-up.

## Operation
- All four asynchronous inputs pass through 2-flop synchronizers. Define ok = lockS_cpu & lockS_vid & ~fxS_cpu & ~fxS_vid, using the synchronized values.
- States: S_DRST, S_WAIT, S_SETTLE, S_RUN, S_FAIL. A single 16-bit counter cnt is cleared on every state entry.
- S_DRST: DCM_RST=1. When cnt==RST_PULSE-1, go to S_WAIT.
- S_WAIT:
  - If ok, go to S_SETTLE.
  - Else if cnt==LOCK_TIMEOUT-1, take the retry path.
- S_SETTLE:
  - If !ok, take the retry path.
  - Else if cnt==SETTLE-1, go to S_RUN and clear RETRY_CNT.
- S_RUN: SYS_RST=0 and READY=1. If !ok, take the retry path.
- Retry path:
  - If RETRY_CNT==RETRY_MAX, go to S_FAIL.
  - Otherwise increment RETRY_CNT and go to S_DRST.
- S_FAIL: FAIL=1, DCM_RST=0, SYS_RST=1. The state is absorbing; only RST exits it.
- Outputs are a registered Moore decode of the state register:
  - DCM_RST=1 only in S_DRST.
  - SYS_RST=0 only in S_RUN.
- Reset values: state S_DRST, cnt 0, DCM_RST 1, SYS_RST 1, READY 0, FAIL 0, RETRY_CNT 0, synchronizers 0.
- Counter compares are against parameter-1 at 16-bit width, so the counter never wraps.
- If lock and the timeout condition coincide in S_WAIT, lock wins.

## Timing
- After RST falls, DCM_RST stays high for exactly RST_PULSE rising edges.
- Input-to-decision latency is 2 cycles (synchronizer) plus 1 cycle (state register).
- SYS_RST deasserts SETTLE+3 cycles after the later of the two raw LOCKED rising edges, provided no drop occurs.
- On lock loss in S_RUN, SYS_RST and DCM_RST rise together 3 cycles after the raw LOCKED falls.
- A lock glitch shorter than one CLK period may be missed. This is accepted, because the DCM holds LOCKED low for many cycles on real loss.
- RST asserted in any state forces all outputs to their reset values immediately, with no clock required.

## Structure
- Package clkgen_pkg holds:
  - the state enum seq_state_t;
  - default constants DEF_RST_PULSE, DEF_LOCK_TIMEOUT, DEF_SETTLE, DEF_RETRY_MAX.
- Sub-module sync2: a generic 2-flop synchronizer with an asynchronous reset to 0, instantiated four times.
- The FSM and counter live in dcm_lock_seq.

## Test plan
All scenarios use RST_PULSE=4, LOCK_TIMEOUT=20, SETTLE=8, RETRY_MAX=2.
- **Normal bring-up.** Release RST at cycle 0; raise both LOCKED at cycle 10.
  - DCM_RST is high for cycles 0–3.
  - SYS_RST falls and READY rises at cycle 21.
  - RETRY_CNT=0.
- **Lock timeout.** Never assert VID_LOCKED.
  - DCM_RST re-pulses three times in total.
  - RETRY_CNT steps 1, 2.
  - FAIL=1 after the third timeout; SYS_RST remains 1 and DCM_RST remains 0 thereafter.
- **Loss in RUN.** Reach RUN, then drop CPU_LOCKED at cycle N.
  - SYS_RST=1 and DCM_RST=1 at cycle N+3.
  - RETRY_CNT=1.
  - When CPU_LOCKED is restored, RUN is re-reached and RETRY_CNT clears to 0.
- **Settle abort.** Assert CPU_FXSTOP for 3 cycles during S_SETTLE.
  - The FSM returns to S_DRST with RETRY_CNT=1.
  - SYS_RST never drops during the abort.
- **Async reset.** Assert RST mid-S_SETTLE and mid-S_FAIL, between clock edges.
  - Outputs go to their reset values before the next edge.
  - FAIL clears.
- **Coincidence.** Locks rise synchronized exactly at cycle cnt==19 of S_WAIT.
  - The FSM enters S_SETTLE, not the retry path.

Source files
------------

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: state encoding and default timing constants for the DCM lock sequencer.
package clkgen_pkg;
  typedef enum logic [2:0] {S_DRST, S_WAIT, S_SETTLE, S_RUN, S_FAIL} seq_state_t;
  localparam int DEF_RST_PULSE    = 4;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_SETTLE       = 1024;
  localparam int DEF_RETRY_MAX    = 7;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with asynchronous clear.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else     {q, m} <= {m, d};
endmodule

// File: rtl/dcm_lock_seq.sv
// dcm_lock_seq: pulses DCM reset, waits for both locks, settles, then releases system reset with bounded retries.
module dcm_lock_seq
  import clkgen_pkg::*;
#(
  parameter int RST_PULSE    = DEF_RST_PULSE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int SETTLE       = DEF_SETTLE,
  parameter int RETRY_MAX    = DEF_RETRY_MAX
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CPU_LOCKED,
  input  logic       VID_LOCKED,
  input  logic       CPU_FXSTOP,
  input  logic       VID_FXSTOP,
  output logic       DCM_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [2:0] RETRY_CNT
);
  localparam logic [15:0] PULSE_END   = 16'(RST_PULSE - 1);
  localparam logic [15:0] TIMEOUT_END = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_END  = 16'(SETTLE - 1);
  localparam logic [2:0]  RETRY_LIM   = 3'(RETRY_MAX);
  seq_state_t  state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [2:0]  retry_nx;
  logic        lk_cpu, lk_vid, fx_cpu, fx_vid, ok, retry, at_max;
  logic        dcm_rst_nx, sys_rst_nx, ready_nx, fail_nx;
  sync2 u_lk_cpu (.clk(CLK), .rst(RST), .d(CPU_LOCKED), .q(lk_cpu));
  sync2 u_lk_vid (.clk(CLK), .rst(RST), .d(VID_LOCKED), .q(lk_vid));
  sync2 u_fx_cpu (.clk(CLK), .rst(RST), .d(CPU_FXSTOP), .q(fx_cpu));
  sync2 u_fx_vid (.clk(CLK), .rst(RST), .d(VID_FXSTOP), .q(fx_vid));
  assign ok     = lk_cpu & lk_vid & ~fx_cpu & ~fx_vid;
  assign at_max = RETRY_CNT == RETRY_LIM;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state     <= S_DRST;
      cnt       <= '0;
      RETRY_CNT <= '0;
      DCM_RST   <= 1'b1;
      SYS_RST   <= 1'b1;
      READY     <= 1'b0;
      FAIL      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      RETRY_CNT <= retry_nx;
      DCM_RST   <= dcm_rst_nx;
      SYS_RST   <= sys_rst_nx;
      READY     <= ready_nx;
      FAIL      <= fail_nx;
    end
  always_comb begin
    state_nx = state;
    retry_nx = RETRY_CNT;
    retry    = 1'b0;
    case (state)
      S_DRST:   if (cnt == PULSE_END) state_nx = S_WAIT;
      S_WAIT:   if (ok) state_nx = S_SETTLE;
                else if (cnt == TIMEOUT_END) retry = 1'b1;
      S_SETTLE: if (!ok) retry = 1'b1;
                else if (cnt == SETTLE_END) begin
                  state_nx = S_RUN;
                  retry_nx = '0;
                end
      S_RUN:    if (!ok) retry = 1'b1;
      default:  ;
    endcase
    if (retry) begin
      state_nx = at_max ? S_FAIL : S_DRST;
      retry_nx = at_max ? RETRY_CNT : RETRY_CNT + 3'd1;
    end
    // Counter only runs in the timed states so it can never wrap while idling in RUN or FAIL.
    cnt_nx = (state_nx != state) ? '0 : (state == S_RUN || state == S_FAIL) ? cnt : cnt + 16'd1;
  end
  // Outputs register the decode of the next state so they line up with the state register.
  always_comb begin
    dcm_rst_nx = state_nx == S_DRST;
    sys_rst_nx = state_nx != S_RUN;
    ready_nx   = state_nx == S_RUN;
    fail_nx    = state_nx == S_FAIL;
  end
endmodule

// File: tb/tb_dcm_lock_seq.sv
// tb_dcm_lock_seq: directed scenarios plus random lock/fxstop traffic against a cycle-level behavioural model.
module tb_dcm_lock_seq;
  localparam int RP = 4, TO = 20, ST = 8, RM = 2;
  localparam int P_DRST = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_FAIL = 4;
  logic clk = 0, rst = 1, cpu_l = 0, vid_l = 0, cpu_fx = 0, vid_fx = 0;
  logic dcm_rst, sys_rst, ready, fail;
  logic [2:0] retry_cnt;
  logic [6:0] obs;
  int checks = 0, errors = 0, cyc = 0;
  int ph = P_DRST, t_entry = 0, rc = 0;
  logic q[$];
  int first_ready, first_fail, dcm_hi, pulses, sys_low;
  logic prev;

  always #5 clk = ~clk;

  dcm_lock_seq #(.RST_PULSE(RP), .LOCK_TIMEOUT(TO), .SETTLE(ST), .RETRY_MAX(RM)) dut (
    .CLK(clk), .RST(rst), .CPU_LOCKED(cpu_l), .VID_LOCKED(vid_l),
    .CPU_FXSTOP(cpu_fx), .VID_FXSTOP(vid_fx), .DCM_RST(dcm_rst), .SYS_RST(sys_rst),
    .READY(ready), .FAIL(fail), .RETRY_CNT(retry_cnt)
  );

  assign obs = {dcm_rst, sys_rst, ready, fail, retry_cnt};

  function automatic logic [6:0] exp_out();
    return {ph == P_DRST, ph != P_RUN, ph == P_RUN, ph == P_FAIL, 3'(rc)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, o, e);
    end
  endtask

  function automatic void model_reset();
    ph = P_DRST; rc = 0; t_entry = 0; cyc = 0;
    q = {1'b0, 1'b0, 1'b0};
  endfunction

  // Decision at an edge sees the raw "ok" that was presented three edges earlier.
  function automatic void model_step();
    logic okd;
    int el, nph;
    bit rty;
    q.push_front(cpu_l & vid_l & ~cpu_fx & ~vid_fx);
    okd = q[2];
    void'(q.pop_back());
    el = cyc - t_entry;
    nph = ph;
    rty = 0;
    if (ph == P_DRST && el == RP - 1) nph = P_WAIT;
    else if (ph == P_WAIT) begin
      if (okd) nph = P_SETTLE;
      else if (el == TO - 1) rty = 1;
    end else if (ph == P_SETTLE) begin
      if (!okd) rty = 1;
      else if (el == ST - 1) begin nph = P_RUN; rc = 0; end
    end else if (ph == P_RUN && !okd) rty = 1;
    if (rty) begin
      if (rc == RM) nph = P_FAIL;
      else begin rc++; nph = P_DRST; end
    end
    cyc++;
    if (nph != ph) t_entry = cyc;
    ph = nph;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cycle", 16'(obs), 16'(exp_out()));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2 rst = 1;
    #1 chk("async_rst", 16'(obs), 16'b1100000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_release", 16'(obs), 16'(exp_out()));
  endtask

  initial begin
    model_reset();
    // Normal bring-up
    reset_dut();
    first_ready = -1;
    dcm_hi = dcm_rst ? 1 : 0;
    for (int i = 1; i <= 30; i++) begin
      if (cyc == 10) begin cpu_l = 1; vid_l = 1; end
      tick();
      if (dcm_rst) dcm_hi++;
      if (ready && first_ready < 0) first_ready = cyc;
    end
    chk("drst_len", 16'(dcm_hi), 16'd4);
    chk("ready_at", 16'(first_ready), 16'd21);
    chk("retry_zero", 16'(retry_cnt), 16'd0);
    // Loss in RUN
    cpu_l = 0;
    tick();
    tick();
    chk("run_hold", 16'(sys_rst), 16'd0);
    tick();
    chk("loss_rst", 16'({sys_rst, dcm_rst}), 16'b11);
    chk("loss_retry", 16'(retry_cnt), 16'd1);
    cpu_l = 1;
    repeat (30) tick();
    chk("rerun", 16'({ready, retry_cnt}), 16'b1000);
    // Lock timeout into FAIL
    vid_l = 0;
    reset_dut();
    pulses = dcm_rst ? 1 : 0;
    prev = dcm_rst;
    first_fail = -1;
    repeat (90) begin
      tick();
      if (dcm_rst && !prev) pulses++;
      prev = dcm_rst;
      if (cyc == 30) chk("retry_step1", 16'(retry_cnt), 16'd1);
      if (cyc == 55) chk("retry_step2", 16'(retry_cnt), 16'd2);
      if (fail && first_fail < 0) first_fail = cyc;
    end
    chk("pulses", 16'(pulses), 16'd3);
    chk("fail_at", 16'(first_fail), 16'd72);
    chk("fail_hold", 16'({fail, sys_rst, dcm_rst, retry_cnt}), 16'b110010);
    // Async reset out of FAIL
    reset_dut();
    chk("fail_clear", 16'(fail), 16'd0);
    // Settle abort by a 3-cycle FXSTOP
    vid_l = 1;
    reset_dut();
    sys_low = 0;
    while (cyc < 10) begin
      if (cyc == 7) cpu_fx = 1;
      tick();
      if (!sys_rst) sys_low++;
    end
    cpu_fx = 0;
    chk("abort_state", 16'({dcm_rst, retry_cnt}), 16'b1001);
    chk("abort_sys", 16'(sys_low), 16'd0);
    while (cyc < 18) tick();
    // Async reset in the middle of SETTLE
    reset_dut();
    // Lock arriving exactly at the timeout count
    cpu_l = 0; vid_l = 0;
    reset_dut();
    while (cyc < 24) begin
      if (cyc == 21) begin cpu_l = 1; vid_l = 1; end
      tick();
    end
    chk("coincide", 16'({dcm_rst, retry_cnt}), 16'b0000);
    while (cyc < 32) tick();
    chk("coincide_run", 16'(ready), 16'd1);
    // Random lock/fxstop traffic with occasional resets
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      cpu_l  = cpu_l ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 7) == 0);
      vid_l  = vid_l ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 7) == 0);
      cpu_fx = $urandom_range(0, 79) == 0;
      vid_fx = $urandom_range(0, 79) == 0;
      if ($urandom_range(0, 149) == 0) reset_dut();
      else tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
